// File: rtl/associative_memory_multiclass.sv
// Folded multi-task associative memory: per-task argmin Hamming distance of one
// query against NUM_CLASSES prototypes, accumulated one HV slice per cycle.
`ifndef AM_NUM_FOLDS
`define AM_NUM_FOLDS 10
`endif

module associative_memory_multiclass #(
    parameter int HV_DIMENSION = 2000,
    parameter int AM_NUM_FOLDS = `AM_NUM_FOLDS,
    parameter int NUM_TASKS    = 2,
    parameter int NUM_CLASSES  = 2,
    localparam int AM_FOLD_WIDTH  = HV_DIMENSION / AM_NUM_FOLDS,
    localparam int FOLD_CNT_WIDTH = (AM_NUM_FOLDS > 1) ? $clog2(AM_NUM_FOLDS) : 1,
    localparam int CLASS_WIDTH    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int DIST_WIDTH     = $clog2(HV_DIMENSION + 1)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          hvin_valid,
    output logic                                          hvin_ready,
    input  logic [HV_DIMENSION-1:0]                       hvin,
    input  logic [NUM_TASKS*NUM_CLASSES*HV_DIMENSION-1:0] prototypes,
    output logic                                          dout_valid,
    input  logic                                          dout_ready,
    output logic [NUM_TASKS*CLASS_WIDTH-1:0]              class_out,
    output logic [NUM_TASKS*DIST_WIDTH-1:0]               dist_out
);

    localparam int NUM_PROTOS = NUM_TASKS * NUM_CLASSES;
    localparam logic [FOLD_CNT_WIDTH-1:0] LAST_FOLD = FOLD_CNT_WIDTH'(AM_NUM_FOLDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, OUTPUT} state_t;

    state_t                                 state_q;
    logic                                   ready_q;
    logic                                   dout_valid_q;
    logic [FOLD_CNT_WIDTH-1:0]              fold_q;
    logic [HV_DIMENSION-1:0]                query_q;
    logic [NUM_PROTOS-1:0][DIST_WIDTH-1:0]  acc_q, acc_d;
    logic [NUM_TASKS-1:0][CLASS_WIDTH-1:0]  class_q, class_d;
    logic [NUM_TASKS-1:0][DIST_WIDTH-1:0]   dist_q, dist_d;
    logic [AM_FOLD_WIDTH-1:0]               q_slice;

    function automatic logic [DIST_WIDTH-1:0] popcount(input logic [AM_FOLD_WIDTH-1:0] v);
        logic [DIST_WIDTH-1:0] n;
        n = '0;
        for (int b = 0; b < AM_FOLD_WIDTH; b++) n += DIST_WIDTH'(v[b]);
        return n;
    endfunction

    always_comb begin
        q_slice = query_q[int'(fold_q)*AM_FOLD_WIDTH +: AM_FOLD_WIDTH];
        for (int i = 0; i < NUM_PROTOS; i++)
            acc_d[i] = acc_q[i] + popcount(q_slice ^
                       prototypes[i*HV_DIMENSION + int'(fold_q)*AM_FOLD_WIDTH +: AM_FOLD_WIDTH]);
    end

    // Strict less-than while scanning upward keeps ties on the lowest class.
    always_comb begin
        class_d = '0;
        dist_d  = '0;
        for (int t = 0; t < NUM_TASKS; t++) begin
            dist_d[t] = acc_q[t*NUM_CLASSES];
            for (int c = 1; c < NUM_CLASSES; c++) begin
                if (acc_q[t*NUM_CLASSES + c] < dist_d[t]) begin
                    dist_d[t]  = acc_q[t*NUM_CLASSES + c];
                    class_d[t] = CLASS_WIDTH'(c);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            dout_valid_q <= 1'b0;
            fold_q       <= '0;
            query_q      <= '0;
            acc_q        <= '0;
            class_q      <= '0;
            dist_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hvin_valid) begin
                        query_q <= hvin;
                        acc_q   <= '0;
                        fold_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (fold_q == LAST_FOLD) state_q <= COMPARE;
                    else                     fold_q  <= fold_q + 1'b1;
                end
                COMPARE: begin
                    class_q      <= class_d;
                    dist_q       <= dist_d;
                    dout_valid_q <= 1'b1;
                    state_q      <= OUTPUT;
                end
                OUTPUT: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ready_q is the registered IDLE decode; masking with rst holds it low in the reset cycle.
    assign hvin_ready = ready_q & ~rst;
    assign dout_valid = dout_valid_q;
    assign class_out  = class_q;
    assign dist_out   = dist_q;

endmodule

// File: tb/tb_associative_memory_multiclass.sv
// Self-checking bench: three configurations (2x2 default folds, 3x5 with 100 folds,
// 2x2 with one fold) checked against a full-width Hamming argmin model.
module tb_associative_memory_multiclass;
    localparam int HV  = 2000;
    localparam int DW  = 11;
    localparam int D_F = 10;
    localparam int M_F = 100;
    localparam int S_F = 1;
    localparam int M_CW = 3;
    localparam int TMO = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int mdl_cls [3];
    int mdl_dist[3];

    logic            d_valid = 1'b0, d_dready = 1'b1, d_ready, d_dvalid;
    logic [HV-1:0]   d_hv = '0;
    logic [4*HV-1:0] d_pr = '0;
    logic [1:0]      d_cls;
    logic [2*DW-1:0] d_dist;
    int              d_exp_cls[2], d_exp_dist[2];

    logic             m_valid = 1'b0, m_dready = 1'b1, m_ready, m_dvalid;
    logic [HV-1:0]    m_hv = '0;
    logic [15*HV-1:0] m_pr = '0;
    logic [3*M_CW-1:0] m_cls;
    logic [3*DW-1:0]  m_dist;
    int               m_exp_cls[3], m_exp_dist[3];

    logic            s_valid = 1'b0, s_dready = 1'b1, s_ready, s_dvalid;
    logic [HV-1:0]   s_hv = '0;
    logic [4*HV-1:0] s_pr = '0;
    logic [1:0]      s_cls;
    logic [2*DW-1:0] s_dist;
    int              s_exp_cls[2], s_exp_dist[2];
    int              s_res = 0;

    associative_memory_multiclass #(.HV_DIMENSION(HV), .AM_NUM_FOLDS(D_F), .NUM_TASKS(2), .NUM_CLASSES(2)) u_d (
        .clk(clk), .rst(rst), .hvin_valid(d_valid), .hvin_ready(d_ready), .hvin(d_hv),
        .prototypes(d_pr), .dout_valid(d_dvalid), .dout_ready(d_dready),
        .class_out(d_cls), .dist_out(d_dist));

    associative_memory_multiclass #(.HV_DIMENSION(HV), .AM_NUM_FOLDS(M_F), .NUM_TASKS(3), .NUM_CLASSES(5)) u_m (
        .clk(clk), .rst(rst), .hvin_valid(m_valid), .hvin_ready(m_ready), .hvin(m_hv),
        .prototypes(m_pr), .dout_valid(m_dvalid), .dout_ready(m_dready),
        .class_out(m_cls), .dist_out(m_dist));

    associative_memory_multiclass #(.HV_DIMENSION(HV), .AM_NUM_FOLDS(S_F), .NUM_TASKS(2), .NUM_CLASSES(2)) u_s (
        .clk(clk), .rst(rst), .hvin_valid(s_valid), .hvin_ready(s_ready), .hvin(s_hv),
        .prototypes(s_pr), .dout_valid(s_dvalid), .dout_ready(s_dready),
        .class_out(s_cls), .dist_out(s_dist));

    task automatic chk(input string nm, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    // Plain full-vector Hamming distance, lowest class wins ties.
    task automatic model(input logic [15*HV-1:0] pr, input logic [HV-1:0] hv, input int nt, input int nc);
        int d;
        for (int t = 0; t < 3; t++) begin mdl_cls[t] = 0; mdl_dist[t] = 0; end
        for (int t = 0; t < nt; t++)
            for (int c = 0; c < nc; c++) begin
                d = $countones(hv ^ pr[(t*nc + c)*HV +: HV]);
                if (c == 0 || d < mdl_dist[t]) begin mdl_cls[t] = c; mdl_dist[t] = d; end
            end
    endtask

    function automatic logic [HV-1:0] ones(input int lo, input int n);
        logic [HV-1:0] v = '0;
        for (int i = 0; i < n; i++) v[lo + i] = 1'b1;
        return v;
    endfunction

    function automatic logic [HV-1:0] rand_hv();
        logic [HV-1:0] v;
        for (int i = 0; i < HV; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (d_dvalid)
                for (int t = 0; t < 2; t++) begin
                    chk("d_class", d_cls[t], d_exp_cls[t]);
                    chk("d_dist", d_dist[t*DW +: DW], d_exp_dist[t]);
                end
            if (m_dvalid)
                for (int t = 0; t < 3; t++) begin
                    chk("m_class", m_cls[t*M_CW +: M_CW], m_exp_cls[t]);
                    chk("m_dist", m_dist[t*DW +: DW], m_exp_dist[t]);
                end
            if (s_dvalid)
                for (int t = 0; t < 2; t++) begin
                    chk("s_class", s_cls[t], s_exp_cls[t]);
                    chk("s_dist", s_dist[t*DW +: DW], s_exp_dist[t]);
                end
        end
    end

    always @(posedge clk) if (!rst && s_dvalid && s_dready) s_res <= s_res + 1;

    task automatic d_set(input int c0, input int c1, input int e0, input int e1);
        d_exp_cls[0] = c0; d_exp_cls[1] = c1; d_exp_dist[0] = e0; d_exp_dist[1] = e1;
    endtask

    // Issue one query to u_d; optionally check latency and complete the handshake.
    task automatic d_query(input logic [HV-1:0] hv, input bit lat, input bit hs);
        int n = 0;
        @(negedge clk);
        while (!d_ready && n < TMO) begin @(negedge clk); n++; end
        chk("d_accept_wait", n < TMO, 1);
        d_hv = hv; d_valid = 1'b1;
        @(posedge clk); #1 d_valid = 1'b0;
        n = 0;
        while (!d_dvalid && n < TMO) begin @(posedge clk); #1; n++; end
        if (lat) chk("d_latency", n, D_F + 1);
        else     chk("d_result_wait", n < TMO, 1);
        if (hs) begin @(posedge clk); #1; end
    endtask

    task automatic m_query(input logic [HV-1:0] hv, input bit lat);
        int n = 0;
        @(negedge clk);
        while (!m_ready && n < TMO) begin @(negedge clk); n++; end
        chk("m_accept_wait", n < TMO, 1);
        model(m_pr, hv, 3, 5);
        for (int t = 0; t < 3; t++) begin m_exp_cls[t] = mdl_cls[t]; m_exp_dist[t] = mdl_dist[t]; end
        m_hv = hv; m_valid = 1'b1;
        @(posedge clk); #1 m_valid = 1'b0;
        n = 0;
        while (!m_dvalid && n < TMO) begin @(posedge clk); #1; n++; end
        if (lat) chk("m_latency", n, M_F + 1);
        else     chk("m_result_wait", n < TMO, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HV-1:0] hv;
        longint ta[6];
        int n;

        repeat (3) @(negedge clk);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_d_dvalid", d_dvalid, 0);
        chk("rst_d_class", d_cls, 0);
        chk("rst_d_dist", d_dist, 0);
        chk("rst_m_dvalid", m_dvalid, 0);
        chk("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_ready", d_ready, 1);
        chk("post_rst_m_ready", m_ready, 1);
        chk("post_rst_s_ready", s_ready, 1);

        // Distances 5/100 and 1999/3, slices straddling fold boundaries.
        d_pr = {ones(399, 3), ones(0, 1999), ones(150, 100), ones(198, 5)};
        model((15*HV)'(d_pr), '0, 2, 2);
        chk("pin_basic_cls0", mdl_cls[0], 0);
        chk("pin_basic_cls1", mdl_cls[1], 1);
        chk("pin_basic_dist0", mdl_dist[0], 5);
        chk("pin_basic_dist1", mdl_dist[1], 3);
        d_set(0, 1, 5, 3);
        d_query('0, 1, 1);
        chk("basic_class_held", d_cls, 2'b10);
        chk("basic_dist_held", d_dist, {11'd3, 11'd5});

        // Tie in task 0 (40 vs 40) resolves to class 0.
        d_pr = {ones(1000, 40), ones(1500, 50), ones(580, 40), ones(190, 40)};
        model((15*HV)'(d_pr), '0, 2, 2);
        chk("pin_tie_cls0", mdl_cls[0], 0);
        chk("pin_tie_dist0", mdl_dist[0], 40);
        d_set(0, 1, 40, 40);
        d_query('0, 1, 1);

        d_set(0, 1, 20, 60);
        d_query(ones(190, 20), 1, 1);

        // Backpressure: result held for 20 cycles, no new acceptance.
        d_dready = 1'b0;
        d_set(0, 1, 80, 0);
        d_query(ones(1000, 40), 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_ready_low", d_ready, 0);
            chk("bp_valid_high", d_dvalid, 1);
        end
        d_dready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after", d_ready, 1);
        chk("bp_valid_after", d_dvalid, 0);

        // Reset in the middle of accumulation, then a clean query.
        @(negedge clk);
        d_hv = rand_hv(); d_valid = 1'b1;
        @(posedge clk); #1 d_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", d_ready, 0);
        chk("midrst_dvalid", d_dvalid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ready", d_ready, 1);
        chk("midrst_idle_dvalid", d_dvalid, 0);
        d_set(0, 1, 80, 0);
        d_query(ones(1000, 40), 1, 1);

        // 3 tasks x 5 classes, 100 folds, random queries with exact matches and complements.
        for (int i = 0; i < 15; i++) m_pr[i*HV +: HV] = rand_hv();
        for (int i = 0; i < 200; i++) begin
            if (i >= 196) begin
                for (int c = 0; c < 5; c++) m_pr[c*HV +: HV] = '1;
                hv = (i == 196) ? '0 : rand_hv();
            end else if (i % 8 == 0) hv = m_pr[((i % 3)*5 + (i % 5))*HV +: HV];
            else if (i % 8 == 1)     hv = ~m_pr[((i % 3)*5 + (i % 5))*HV +: HV];
            else                     hv = rand_hv();
            if (i == 0) begin
                model(m_pr, hv, 3, 5);
                chk("pin_exact_dist", mdl_dist[0], 0);
            end
            if (i == 196) begin
                model(m_pr, hv, 3, 5);
                chk("pin_max_dist", mdl_dist[0], 2000);
                chk("pin_max_cls", mdl_cls[0], 0);
            end
            m_query(hv, i == 0);
        end

        // One fold, back-to-back queries with hvin_valid held high.
        s_pr = {ones(1000, 40), ones(1500, 50), ones(580, 40), ones(190, 40)};
        for (int k = 0; k < 6; k++) begin
            hv = rand_hv();
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 50) begin @(negedge clk); n++; end
            chk("s_accept_wait", n < 50, 1);
            model((15*HV)'(s_pr), hv, 2, 2);
            for (int t = 0; t < 2; t++) begin s_exp_cls[t] = mdl_cls[t]; s_exp_dist[t] = mdl_dist[t]; end
            s_hv = hv; s_valid = 1'b1;
            @(posedge clk);
            ta[k] = $time;
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 1; k < 6; k++) chk("s_interval", (ta[k] - ta[k-1]) / 10, S_F + 3);
        chk("s_results", s_res, 6);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/associative_memory_multiclass.md
# associative_memory_multiclass

Folded, parametrised associative memory that replaces the fixed two-output classifier at the end of the sensor-fusion pipeline, after the temporal encoder. It accepts one query hypervector from the temporal encoder and compares it against NUM_CLASSES prototype hypervectors for each of NUM_TASKS independent tasks, one fold per cycle. It returns the per-task argmin-Hamming class index and the minimum distance. With NUM_TASKS=2 and NUM_CLASSES=2, class_out[0] is arousal and class_out[1] is valence.

## Interface
- HV_DIMENSION, 2000, query/prototype width in bits
- AM_NUM_FOLDS, `AM_NUM_FOLDS, folds per query; HV_DIMENSION % AM_NUM_FOLDS must equal 0
- NUM_TASKS, 2, independent classification tasks
- NUM_CLASSES, 2, prototypes per task (≥2)
- Derived: AM_FOLD_WIDTH = HV_DIMENSION/AM_NUM_FOLDS; FOLD_CNT_WIDTH = max(1, `ceilLog2(AM_NUM_FOLDS)); CLASS_WIDTH = max(1, `ceilLog2(NUM_CLASSES)); DIST_WIDTH = `ceilLog2(HV_DIMENSION+1)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- hvin_valid  in  1  query valid
- hvin_ready  out  1  block can accept query
- hvin  in  HV_DIMENSION  query hypervector
- prototypes  in  NUM_TASKS*NUM_CLASSES*HV_DIMENSION  static prototypes; task t, class c at [(t*NUM_CLASSES+c)*HV_DIMENSION +: HV_DIMENSION]
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result
- class_out  out  NUM_TASKS*CLASS_WIDTH  winning class of task t at [t*CLASS_WIDTH +: CLASS_WIDTH]
- dist_out  out  NUM_TASKS*DIST_WIDTH  winning distance of task t at [t*DIST_WIDTH +: DIST_WIDTH]

## Operation
- FSM states: IDLE, ACCUM, COMPARE, OUTPUT.
- IDLE: hvin_ready=1. On hvin_valid, register hvin, clear all NUM_TASKS*NUM_CLASSES distance accumulators and fold counter, go to ACCUM.
- ACCUM, fold f = fold counter:
  - Per cycle, for every (t,c), add popcount(q[f*AM_FOLD_WIDTH +: AM_FOLD_WIDTH] ^ p_tc[same slice]) to acc[t][c].
  - Accumulators are DIST_WIDTH bits and cannot overflow.
  - At f = AM_NUM_FOLDS-1, go to COMPARE; otherwise increment f.
- COMPARE, one cycle:
  - Per task, take argmin over classes, scanning c ascending with strict less-than, so ties resolve to the lowest class index.
  - Register class_out and dist_out, go to OUTPUT.
- OUTPUT: dout_valid=1. class_out and dist_out hold stable until dout_valid && dout_ready, then go to IDLE.
- prototypes is sampled during ACCUM only. It must be stable from acceptance to COMPARE; changing it mid-query is undefined.
- rst in any state: go to IDLE, drop the in-flight query, clear accumulators.

## Timing
- Reset values: hvin_ready=0 during the rst cycle and 1 on the first cycle after; dout_valid=0; class_out=0; dist_out=0; fold counter=0.
- hvin_ready is a registered state decode: 1 only in IDLE, with no combinational path from dout_ready.
- Query accepted at edge N: ACCUM covers cycles N+1 through N+AM_NUM_FOLDS, COMPARE is N+AM_NUM_FOLDS+1, and dout_valid rises at N+AM_NUM_FOLDS+2.
- The earliest next acceptance is one cycle after the output handshake, giving a throughput of one query per AM_NUM_FOLDS+3 cycles with dout_ready tied high.
- Once dout_valid asserts, it stays high with outputs unchanged until handshake; outputs keep their last values after handshake.
- AM_NUM_FOLDS=1: one ACCUM cycle, and the fold counter stays 0.
- hvin_valid while not in IDLE is ignored; the upstream holds it.

## Test plan
- Defaults, 2 tasks × 2 classes. hvin=all-0; task0 protos have 5 and 100 ones, task1 protos have 1999 and 3 ones -> class_out={1,0} (task1=1, task0=0), dist_out task0=5, task1=3, dout_valid exactly AM_NUM_FOLDS+2 cycles after acceptance.
- Tie: both classes of a task have 40 ones, hvin=0 -> class 0, dist 40.
- NUM_CLASSES=5, NUM_TASKS=3, 100-fold distances crossing fold boundaries. Compare against a software model over 200 random queries, including dist 0 and dist 2000.
- Backpressure: hold dout_ready=0 for 20 cycles -> outputs stable, hvin_ready=0 throughout. Assert dout_ready -> hvin_ready=1 on the next cycle.
- rst asserted mid-ACCUM -> next cycle is IDLE with dout_valid=0. A following query returns correct results, with no stale accumulation.
- AM_NUM_FOLDS=1 with back-to-back queries and dout_ready=1 -> one result every 4 cycles, all correct.
